pool2d_layer: RTL and testbench

- Streaming 2-D pooling stage for the CNN row pipeline.
- Consumes one image row per handshake: `WIDTH` columns × `CHANNELS` values.
- Reduces non-overlapping `KERNEL_W` × `KERNEL_H` windows by max or average, and emits one pooled row per `KERNEL_H` input rows.
- Successor to the horizontal-only max-pool layer. Adds independent kernel height/width, an average mode, signed arithmetic, partial-group flush on last, and tag propagation.

---
 rtl/pool2d_layer_pkg.sv | 33 +++
 rtl/pool_window_reduce.sv | 51 +++++
 rtl/pool2d_layer.sv | 143 ++++++++++++++
 tb/tb_pool2d_layer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pool2d_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared types and helpers for the 2-D pooling stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    typedef enum logic [0:0] {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    localparam int c_wide_bits = 64;

    function automatic int acc_bits(input int value_bits, input int kw,
                                    input int kh, input int avg);
        return (avg != 0) ? value_bits + $clog2(kw * kh) : value_bits;
    endfunction

    // True when a should be selected over b (a strictly greater). Callers
    // pass operands already extended to the wide width with the right sign.
    function automatic logic cmp_sel_a(input logic [c_wide_bits-1:0] a,
                                       input logic [c_wide_bits-1:0] b,
                                       input logic                   is_signed);
        if (is_signed) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_window_reduce.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_reduce
// Description : Combinational max/sum over one KERNEL_W x CHANNELS window.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_window_reduce
    import pool_pkg::*;
#(
    parameter int KERNEL_W   = 2,
    parameter int CHANNELS   = 1,
    parameter int VALUE_BITS = 8,
    parameter int ACC_BITS   = 8,
    parameter int AVG        = 0,
    parameter int SIGNED     = 1
) (
    input  logic [KERNEL_W-1:0][CHANNELS-1:0][VALUE_BITS-1:0] i_win,
    output logic [CHANNELS-1:0][ACC_BITS-1:0]                 o_part
);

    function automatic logic [ACC_BITS-1:0] to_acc(input logic [VALUE_BITS-1:0] v);
        if (SIGNED != 0) begin
            return ACC_BITS'($signed(v));
        end
        return ACC_BITS'(v);
    endfunction

    function automatic logic [c_wide_bits-1:0] widen(input logic [ACC_BITS-1:0] v);
        if (SIGNED != 0) begin
            return c_wide_bits'($signed(v));
        end
        return c_wide_bits'(v);
    endfunction

    always_comb begin
        o_part = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            o_part[c] = to_acc(i_win[0][c]);
            for (int k = 1; k < KERNEL_W; k++) begin
                if (AVG != 0) begin
                    o_part[c] = o_part[c] + to_acc(i_win[k][c]);
                end else if (cmp_sel_a(widen(to_acc(i_win[k][c])), widen(o_part[c]),
                                       SIGNED != 0)) begin
                    o_part[c] = to_acc(i_win[k][c]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool2d_layer.sv
`default_nettype none
// ============================================================================
// Module      : pool2d_layer
// Description : Streaming non-overlapping 2-D max/average pooling over rows.
// Revision    : 1.0 - initial release
// ============================================================================
module pool2d_layer
    import pool_pkg::*;
#(
    parameter int KERNEL_W   = 2,
    parameter int KERNEL_H   = 2,
    parameter int WIDTH      = 28,
    parameter int CHANNELS   = 1,
    parameter int VALUE_BITS = 8,
    parameter int TAG_WIDTH  = 8,
    parameter int AVG        = 0,
    parameter int SIGNED     = 1
) (
    input  logic                                                    clock_i,
    input  logic                                                    reset_i,
    input  logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0]          in_row_i,
    input  logic                                                    in_row_valid_i,
    output logic                                                    in_row_accept_o,
    input  logic                                                    in_row_last_i,
    input  logic [TAG_WIDTH-1:0]                                    in_row_tag_i,
    output logic [WIDTH/KERNEL_W-1:0][CHANNELS-1:0][VALUE_BITS-1:0] out_row_o,
    output logic                                                    out_row_valid_o,
    output logic                                                    out_row_last_o,
    output logic [TAG_WIDTH-1:0]                                    out_row_tag_o,
    input  logic                                                    out_row_accept_i
);

    localparam int         c_out_cols  = WIDTH / KERNEL_W;
    localparam int         c_win       = KERNEL_W * KERNEL_H;
    localparam int         ACC_BITS    = acc_bits(VALUE_BITS, KERNEL_W, KERNEL_H, AVG);
    localparam int         c_res_shift = ACC_BITS - VALUE_BITS;
    localparam int         c_cnt_bits  = (KERNEL_H > 1) ? $clog2(KERNEL_H) : 1;
    localparam pool_mode_e c_mode      = (AVG != 0) ? POOL_AVG : POOL_MAX;

    if (AVG != 0 && (c_win & (c_win - 1)) != 0) begin : g_bad_kernel
        $error("pool2d_layer: average mode needs a power-of-two window size");
    end

    logic [c_out_cols-1:0][CHANNELS-1:0][ACC_BITS-1:0]   w_part;
    logic [c_out_cols-1:0][CHANNELS-1:0][ACC_BITS-1:0]   w_next;
    logic [c_out_cols-1:0][CHANNELS-1:0][VALUE_BITS-1:0] w_result;
    logic [c_out_cols-1:0][CHANNELS-1:0][ACC_BITS-1:0]   r_acc;
    logic [c_out_cols-1:0][CHANNELS-1:0][VALUE_BITS-1:0] r_out_row;
    logic [c_cnt_bits-1:0]                               r_row_cnt;
    logic [TAG_WIDTH-1:0]                                r_tag;
    logic [TAG_WIDTH-1:0]                                r_out_tag;
    logic                                                r_out_valid;
    logic                                                r_out_last;
    logic                                                w_take;
    logic                                                w_first;
    logic                                                w_group_done;

    for (genvar j = 0; j < c_out_cols; j++) begin : g_win
        pool_window_reduce #(
            .KERNEL_W   (KERNEL_W),
            .CHANNELS   (CHANNELS),
            .VALUE_BITS (VALUE_BITS),
            .ACC_BITS   (ACC_BITS),
            .AVG        (AVG),
            .SIGNED     (SIGNED)
        ) u_reduce (
            .i_win  (in_row_i[j*KERNEL_W +: KERNEL_W]),
            .o_part (w_part[j])
        );
    end

    function automatic logic [c_wide_bits-1:0] widen(input logic [ACC_BITS-1:0] v);
        if (SIGNED != 0) begin
            return c_wide_bits'($signed(v));
        end
        return c_wide_bits'(v);
    endfunction

    assign in_row_accept_o = !r_out_valid || out_row_accept_i;
    assign w_take          = in_row_valid_i && in_row_accept_o;
    assign w_first         = (r_row_cnt == '0);
    assign w_group_done    = in_row_last_i || (r_row_cnt == c_cnt_bits'(KERNEL_H - 1));

    // Average output is acc >>> log2(window); since the quotient always fits
    // in VALUE_BITS, that shift-and-truncate is exactly the upper slice.
    always_comb begin
        w_next   = '0;
        w_result = '0;
        for (int j = 0; j < c_out_cols; j++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_first) begin
                    w_next[j][c] = w_part[j][c];
                end else if (c_mode == POOL_AVG) begin
                    w_next[j][c] = r_acc[j][c] + w_part[j][c];
                end else if (cmp_sel_a(widen(w_part[j][c]), widen(r_acc[j][c]),
                                       SIGNED != 0)) begin
                    w_next[j][c] = w_part[j][c];
                end else begin
                    w_next[j][c] = r_acc[j][c];
                end
                w_result[j][c] = w_next[j][c][c_res_shift +: VALUE_BITS];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_row_cnt   <= '0;
            r_acc       <= '0;
            r_tag       <= '0;
            r_out_row   <= '0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (out_row_accept_i) begin
                r_out_valid <= 1'b0;
            end
            if (w_take) begin
                r_acc <= w_next;
                if (w_first) begin
                    r_tag <= in_row_tag_i;
                end
                if (w_group_done) begin
                    r_row_cnt   <= '0;
                    r_out_row   <= w_result;
                    r_out_valid <= 1'b1;
                    r_out_last  <= in_row_last_i;
                    r_out_tag   <= w_first ? in_row_tag_i : r_tag;
                end else begin
                    r_row_cnt <= r_row_cnt + 1'b1;
                end
            end
        end
    end

    assign out_row_o       = r_out_row;
    assign out_row_valid_o = r_out_valid;
    assign out_row_last_o  = r_out_last;
    assign out_row_tag_o   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_pool2d_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool2d_layer
// Description : Directed self-checking bench for pool2d_layer (max/avg/odd).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool2d_layer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // max-mode, unsigned, WIDTH=4
    logic [3:0][0:0][7:0] m_in_row;
    logic                 m_in_valid, m_in_acc, m_in_last;
    logic [7:0]           m_in_tag;
    logic [1:0][0:0][7:0] m_out_row;
    logic                 m_out_valid, m_out_last, m_out_acc;
    logic [7:0]           m_out_tag;

    // average-mode, signed, WIDTH=4
    logic [3:0][0:0][7:0] a_in_row;
    logic                 a_in_valid, a_in_acc, a_in_last;
    logic [7:0]           a_in_tag;
    logic [1:0][0:0][7:0] a_out_row;
    logic                 a_out_valid, a_out_last, a_out_acc;
    logic [7:0]           a_out_tag;

    // max-mode, signed, WIDTH=5
    logic [4:0][0:0][7:0] o_in_row;
    logic                 o_in_valid, o_in_acc, o_in_last;
    logic [7:0]           o_in_tag;
    logic [1:0][0:0][7:0] o_out_row;
    logic                 o_out_valid, o_out_last, o_out_acc;
    logic [7:0]           o_out_tag;

    pool2d_layer #(.KERNEL_W(2), .KERNEL_H(2), .WIDTH(4), .CHANNELS(1), .VALUE_BITS(8),
                   .TAG_WIDTH(8), .AVG(0), .SIGNED(0)) dut_max (
        .clock_i(clk), .reset_i(rst),
        .in_row_i(m_in_row), .in_row_valid_i(m_in_valid), .in_row_accept_o(m_in_acc),
        .in_row_last_i(m_in_last), .in_row_tag_i(m_in_tag),
        .out_row_o(m_out_row), .out_row_valid_o(m_out_valid), .out_row_last_o(m_out_last),
        .out_row_tag_o(m_out_tag), .out_row_accept_i(m_out_acc)
    );

    pool2d_layer #(.KERNEL_W(2), .KERNEL_H(2), .WIDTH(4), .CHANNELS(1), .VALUE_BITS(8),
                   .TAG_WIDTH(8), .AVG(1), .SIGNED(1)) dut_avg (
        .clock_i(clk), .reset_i(rst),
        .in_row_i(a_in_row), .in_row_valid_i(a_in_valid), .in_row_accept_o(a_in_acc),
        .in_row_last_i(a_in_last), .in_row_tag_i(a_in_tag),
        .out_row_o(a_out_row), .out_row_valid_o(a_out_valid), .out_row_last_o(a_out_last),
        .out_row_tag_o(a_out_tag), .out_row_accept_i(a_out_acc)
    );

    pool2d_layer #(.KERNEL_W(2), .KERNEL_H(2), .WIDTH(5), .CHANNELS(1), .VALUE_BITS(8),
                   .TAG_WIDTH(8), .AVG(0), .SIGNED(1)) dut_odd (
        .clock_i(clk), .reset_i(rst),
        .in_row_i(o_in_row), .in_row_valid_i(o_in_valid), .in_row_accept_o(o_in_acc),
        .in_row_last_i(o_in_last), .in_row_tag_i(o_in_tag),
        .out_row_o(o_out_row), .out_row_valid_o(o_out_valid), .out_row_last_o(o_out_last),
        .out_row_tag_o(o_out_tag), .out_row_accept_i(o_out_acc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Row element 0 is column 0 (least-significant slot).
    function automatic logic [31:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
    endfunction

    function automatic logic [39:0] pack5(input int c0, input int c1, input int c2,
                                          input int c3, input int c4);
        return {c4[7:0], c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
    endfunction

    initial begin
        m_in_row = '0; m_in_valid = 0; m_in_last = 0; m_in_tag = '0; m_out_acc = 1;
        a_in_row = '0; a_in_valid = 0; a_in_last = 0; a_in_tag = '0; a_out_acc = 1;
        o_in_row = '0; o_in_valid = 0; o_in_last = 0; o_in_tag = '0; o_out_acc = 1;
        repeat (2) step();

        // Reset state
        check("rst_valid", m_out_valid, 0);
        check("rst_row", m_out_row, 0);
        check("rst_tag", m_out_tag, 0);
        check("rst_last", m_out_last, 0);
        check("rst_in_acc", m_in_acc, 1);
        check("rst_avg_valid", a_out_valid, 0);
        rst = 0;

        // First rows: max unsigned, average signed, odd width
        m_in_row = pack4(1, 5, 3, 2);   m_in_tag = 7; m_in_valid = 1;
        a_in_row = pack4(-4, -2, 6, 2); a_in_tag = 1; a_in_valid = 1;
        o_in_row = pack5(1, -3, -8, -5, 127); o_in_tag = 30; o_in_valid = 1;
        check("max_in_acc", m_in_acc, 1);
        step();
        check("max_not_early", m_out_valid, 0);
        m_in_row = pack4(4, 0, 7, 8);   m_in_tag = 8;
        a_in_row = pack4(0, -2, 3, 1);  a_in_tag = 2;
        o_in_row = pack5(-2, -4, -6, -7, 127); o_in_tag = 31;
        step();
        check("max_valid", m_out_valid, 1);
        check("max_row", m_out_row, 64'h0805);
        check("max_tag", m_out_tag, 7);
        check("max_last", m_out_last, 0);
        check("avg_valid", a_out_valid, 1);
        check("avg_row", a_out_row, 64'h03FE);
        check("avg_tag", a_out_tag, 1);
        check("odd_valid", o_out_valid, 1);
        check("odd_row", o_out_row, 64'hFB01);
        check("odd_tag", o_out_tag, 30);
        m_in_valid = 0;
        o_in_valid = 0;
        a_in_row = pack4(-1, 0, 3, 0); a_in_tag = 3;
        step();
        check("max_clear", m_out_valid, 0);
        check("avg_clear", a_out_valid, 0);
        a_in_row = pack4(0, 0, 0, 0);  a_in_tag = 4;
        step();
        check("avg_floor_row", a_out_row, 64'h00FF);
        check("avg_floor_valid", a_out_valid, 1);
        a_in_valid = 0;
        step();
        check("avg_floor_clear", a_out_valid, 0);

        // Backpressure with same-edge reload
        m_out_acc = 0;
        m_in_row = pack4(10, 20, 30, 40); m_in_tag = 3; m_in_last = 0; m_in_valid = 1;
        step();
        m_in_row = pack4(11, 5, 6, 50);   m_in_tag = 4;
        step();
        check("bp_a_valid", m_out_valid, 1);
        check("bp_a_row", m_out_row, 64'h3214);
        check("bp_a_tag", m_out_tag, 3);
        check("bp_in_acc_low", m_in_acc, 0);
        m_in_row = pack4(60, 1, 2, 3);    m_in_tag = 5; m_in_last = 1;
        step();
        check("bp_hold_row", m_out_row, 64'h3214);
        check("bp_hold_valid", m_out_valid, 1);
        check("bp_hold_in_acc", m_in_acc, 0);
        m_out_acc = 1;
        #1;
        check("bp_in_acc_high", m_in_acc, 1);
        step();
        check("bp_b_valid", m_out_valid, 1);
        check("bp_b_row", m_out_row, 64'h033C);
        check("bp_b_tag", m_out_tag, 5);
        check("bp_b_last", m_out_last, 1);
        m_in_valid = 0; m_in_last = 0;
        step();
        check("bp_no_dup", m_out_valid, 0);

        // Partial final group, then a fresh image
        m_in_row = pack4(1, 2, 3, 4); m_in_tag = 10; m_in_valid = 1;
        step();
        m_in_row = pack4(5, 6, 7, 8); m_in_tag = 11;
        step();
        check("pf_g1_row", m_out_row, 64'h0806);
        check("pf_g1_last", m_out_last, 0);
        m_in_row = pack4(9, 1, 2, 3); m_in_tag = 12; m_in_last = 1;
        step();
        check("pf_g2_valid", m_out_valid, 1);
        check("pf_g2_row", m_out_row, 64'h0309);
        check("pf_g2_last", m_out_last, 1);
        check("pf_g2_tag", m_out_tag, 12);
        m_in_row = pack4(2, 2, 2, 2); m_in_tag = 13; m_in_last = 0;
        step();
        check("pf_new_first", m_out_valid, 0);
        m_in_row = pack4(1, 7, 1, 1); m_in_tag = 14;
        step();
        check("pf_g3_row", m_out_row, 64'h0207);
        check("pf_g3_tag", m_out_tag, 13);
        check("pf_g3_last", m_out_last, 0);

        // Reset mid-group
        m_in_row = pack4(100, 100, 100, 100); m_in_tag = 20;
        step();
        m_in_valid = 0;
        rst = 1;
        step();
        rst = 0;
        check("mr_valid", m_out_valid, 0);
        check("mr_row", m_out_row, 0);
        check("mr_tag", m_out_tag, 0);
        check("mr_last", m_out_last, 0);
        check("mr_in_acc", m_in_acc, 1);
        m_in_row = pack4(2, 2, 2, 2); m_in_tag = 21; m_in_valid = 1;
        step();
        check("mr_no_early", m_out_valid, 0);
        m_in_row = pack4(1, 1, 1, 1); m_in_tag = 22;
        step();
        check("mr_out_valid", m_out_valid, 1);
        check("mr_out_row", m_out_row, 64'h0202);
        check("mr_out_tag", m_out_tag, 21);
        m_in_valid = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
